// File: rtl/cfs_apb_arbiter_if.sv
// APB bus between the cfs_apb_arbiter (master) and the Aligner register slave.
// The address width follows the arbiter's APB_ADDR_WIDTH; the data width is fixed at 32.
interface cfs_apb_arbiter_if #(
  parameter int unsigned APB_ADDR_WIDTH = 16
) ();
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [31:0]               pwdata;
  logic                      pready;
  logic [31:0]               prdata;
  logic                      pslverr;

  modport master (
    output paddr,
    output pwrite,
    output psel,
    output penable,
    output pwdata,
    input  pready,
    input  prdata,
    input  pslverr
  );

  modport slave (
    input  paddr,
    input  pwrite,
    input  psel,
    input  penable,
    input  pwdata,
    output pready,
    output prdata,
    output pslverr
  );
endinterface

// File: rtl/cfs_apb_arbiter.sv
// Round-robin APB master sharing one APB slave between NUM_REQ req/rsp requesters.
// Optional ACCESS timeout is enabled by defining CFS_APB_ARB_TIMEOUT_EN.
module cfs_apb_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned APB_ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                              pclk,
  input  logic                              preset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]             req_wdata,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [31:0]                       rsp_rdata,
  output logic                              rsp_err,
  output logic                              busy,
  cfs_apb_arbiter_if.master                 apb
);

  localparam int unsigned APB_DATA_WIDTH = 32;
  localparam int unsigned GW             = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 256)
  begin : g_param_check
    $error("cfs_apb_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic [NUM_REQ-1:0]        req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      busy_q, busy_d;
  logic [NUM_REQ-1:0]        grant_q, grant_d;
  logic [GW-1:0]             last_grant_q, last_grant_d;
  logic                      timeout_hit;

  logic                      grant_found;
  logic [NUM_REQ-1:0]        grant_oh;
  logic [GW-1:0]             grant_idx;
  logic [APB_ADDR_WIDTH-1:0] win_addr;
  logic [APB_DATA_WIDTH-1:0] win_wdata;
  logic                      win_write;

  // Rotating priority: first set req_valid bit from last_grant+1 upward, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_oh    = '0;
    grant_idx   = '0;
    win_addr    = '0;
    win_wdata   = '0;
    win_write   = 1'b0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      for (int j = 0; j < int'(NUM_REQ); j++) begin
        if (!grant_found && req_valid[j] &&
            (j == (int'(last_grant_q) + k) % int'(NUM_REQ))) begin
          grant_found = 1'b1;
          grant_oh[j] = 1'b1;
          grant_idx   = j[GW-1:0];
          win_addr    = req_addr[j*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
          win_wdata   = req_wdata[j*APB_DATA_WIDTH +: APB_DATA_WIDTH];
          win_write   = req_write[j];
        end
      end
    end
  end

`ifdef CFS_APB_ARB_TIMEOUT_EN
  logic [7:0] timeout_cnt_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      timeout_cnt_q <= 8'd0;
    end else if (state_q == StSetup) begin
      timeout_cnt_q <= 8'd0;
    end else if (state_q == StAccess && !apb.pready) begin
      timeout_cnt_q <= timeout_cnt_q + 8'd1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle.
  assign timeout_hit = (state_q == StAccess) && !apb.pready &&
                       (timeout_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pwrite_d     = pwrite_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          state_d      = StSetup;
          paddr_d      = win_addr;
          pwdata_d     = win_wdata;
          pwrite_d     = win_write;
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          req_ready_d  = grant_oh;
          grant_d      = grant_oh;
          last_grant_d = grant_idx;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        if (apb.pready) begin
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = grant_q;
          rsp_rdata_d = pwrite_q ? '0 : apb.prdata;
          rsp_err_d   = apb.pslverr;
        end else if (timeout_hit) begin
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = grant_q;
          rsp_err_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q      <= StIdle;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pwrite_q     <= pwrite_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cfs_apb_arbiter.sv
// Directed self-checking bench for cfs_apb_arbiter with two requesters.
// Slave read data is {16'hA5A5, paddr}; pready/pslverr are driven step by step.
module tb_cfs_apb_arbiter;
  localparam int unsigned NR = 2;
  localparam int unsigned AW = 16;

  logic             pclk;
  logic             preset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*32-1:0] req_wdata;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             busy;

  int n_chk  = 0;
  int n_pass = 0;

  cfs_apb_arbiter_if #(.APB_ADDR_WIDTH(AW)) apb_if ();

  cfs_apb_arbiter #(
    .NUM_REQ       (NR),
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk     (pclk),
    .preset   (preset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .apb      (apb_if)
  );

  assign apb_if.prdata = {16'hA5A5, apb_if.paddr};

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic       psel_seen;
    logic [1:0] exp_gnt;

    preset         = 1'b1;
    req_valid      = '0;
    req_write      = '0;
    req_addr       = '0;
    req_wdata      = '0;
    apb_if.pready  = 1'b0;
    apb_if.pslverr = 1'b0;
    cyc();
    cyc();

    // Reset state
    check("rst_psel", apb_if.psel, 0);
    check("rst_penable", apb_if.penable, 0);
    check("rst_pwrite", apb_if.pwrite, 0);
    check("rst_paddr", apb_if.paddr, 0);
    check("rst_pwdata", apb_if.pwdata, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);

    // Idle for 20 cycles: psel must never rise
    preset    = 1'b0;
    psel_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      psel_seen = psel_seen | apb_if.psel;
    end
    check("idle_psel_never", psel_seen, 0);
    check("idle_busy", busy, 0);

    // Single write from requester 0, one wait state
    req_valid       = 2'b01;
    req_write       = 2'b01;
    req_addr[15:0]  = 16'h00F0;
    req_wdata[31:0] = 32'h0000_001F;
    cyc();  // T+1 SETUP
    check("wr_setup_psel", apb_if.psel, 1);
    check("wr_setup_penable", apb_if.penable, 0);
    check("wr_setup_ready", req_ready, 2'b01);
    check("wr_setup_paddr", apb_if.paddr, 16'h00F0);
    check("wr_setup_pwrite", apb_if.pwrite, 1);
    check("wr_setup_pwdata", apb_if.pwdata, 32'h1F);
    check("wr_setup_busy", busy, 1);
    req_valid = 2'b00;
    cyc();  // T+2 ACCESS, wait state
    check("wr_acc1_penable", apb_if.penable, 1);
    check("wr_acc1_ready", req_ready, 0);
    cyc();  // T+3 ACCESS, slave ready
    check("wr_acc2_penable", apb_if.penable, 1);
    check("wr_acc2_paddr", apb_if.paddr, 16'h00F0);
    check("wr_acc2_rsp_valid", rsp_valid, 0);
    apb_if.pready = 1'b1;
    cyc();  // T+4 response
    apb_if.pready = 1'b0;
    check("wr_rsp_psel", apb_if.psel, 0);
    check("wr_rsp_penable", apb_if.penable, 0);
    check("wr_rsp_valid", rsp_valid, 2'b01);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    cyc();
    check("wr_rsp_pulse", rsp_valid, 0);

    // Both requesters hold read requests; last grant was requester 0, so order is 1,0,1,0
    req_valid      = 2'b11;
    req_write      = 2'b00;
    req_addr       = {16'h0020, 16'h0010};
    apb_if.pready  = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_gnt = (t % 2 == 0) ? 2'b10 : 2'b01;
      cyc();
      check("rr_ready", req_ready, exp_gnt);
      check("rr_paddr", apb_if.paddr, (exp_gnt == 2'b10) ? 16'h0020 : 16'h0010);
      cyc();
      check("rr_penable", apb_if.penable, 1);
      if (t == 3) req_valid = 2'b00;
      cyc();
      check("rr_rsp_valid", rsp_valid, exp_gnt);
      check("rr_rsp_rdata", rsp_rdata,
            (exp_gnt == 2'b10) ? 32'hA5A5_0020 : 32'hA5A5_0010);
      check("rr_rsp_err", rsp_err, 0);
    end

    // Write with slave error, then a clean read from the other requester
    req_valid       = 2'b01;
    req_write       = 2'b01;
    req_addr[15:0]  = 16'h000C;
    req_wdata[31:0] = 32'h0000_0055;
    cyc();
    check("err_setup_ready", req_ready, 2'b01);
    req_valid      = 2'b00;
    apb_if.pslverr = 1'b1;
    cyc();
    check("err_acc_penable", apb_if.penable, 1);
    cyc();
    check("err_rsp_valid", rsp_valid, 2'b01);
    check("err_rsp_err", rsp_err, 1);
    check("err_rsp_rdata", rsp_rdata, 0);
    apb_if.pslverr  = 1'b0;
    req_valid       = 2'b10;
    req_write       = 2'b00;
    req_addr[31:16] = 16'h0030;
    cyc();
    check("ok_setup_ready", req_ready, 2'b10);
    req_valid = 2'b00;
    cyc();
    cyc();
    check("ok_rsp_valid", rsp_valid, 2'b10);
    check("ok_rsp_err", rsp_err, 0);
    check("ok_rsp_rdata", rsp_rdata, 32'hA5A5_0030);

    // Reset during ACCESS: no response, and requester 0 wins first afterwards
    apb_if.pready  = 1'b0;
    req_valid      = 2'b01;
    req_write      = 2'b00;
    req_addr[15:0] = 16'h0040;
    cyc();
    check("rst_acc_setup_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    cyc();
    check("rst_acc_penable", apb_if.penable, 1);
    preset        = 1'b1;
    apb_if.pready = 1'b1;
    cyc();
    check("rst_acc_psel", apb_if.psel, 0);
    check("rst_acc_penable0", apb_if.penable, 0);
    check("rst_acc_no_rsp", rsp_valid, 0);
    check("rst_acc_busy", busy, 0);
    preset          = 1'b0;
    apb_if.pready   = 1'b0;
    req_valid       = 2'b11;
    req_addr[31:16] = 16'h0050;
    cyc();
    check("post_rst_grant", req_ready, 2'b01);
    check("post_rst_paddr", apb_if.paddr, 16'h0040);
    check("post_rst_no_rsp", rsp_valid, 0);
    req_valid     = 2'b00;
    apb_if.pready = 1'b1;
    cyc();
    cyc();
    apb_if.pready = 1'b0;
    check("post_rst_rsp_valid", rsp_valid, 2'b01);
    check("post_rst_rsp_rdata", rsp_rdata, 32'hA5A5_0040);

`ifdef CFS_APB_ARB_TIMEOUT_EN
    // Slave never ready: abort after 16 ACCESS cycles
    req_valid      = 2'b01;
    req_addr[15:0] = 16'h0060;
    cyc();
    check("to_setup_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    for (int i = 0; i < 16; i++) begin
      cyc();
      check("to_access_held", apb_if.penable, 1);
    end
    cyc();
    check("to_psel", apb_if.psel, 0);
    check("to_penable", apb_if.penable, 0);
    check("to_rsp_valid", rsp_valid, 2'b01);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
